// File: rtl/seg7_pkg.sv
// Shared types and the 7-segment glyph table (a..g, active-high) for the scan counter.
package seg7_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0    = 7'b1111110;
    localparam logic [6:0] SEG_1    = 7'b0110000;
    localparam logic [6:0] SEG_2    = 7'b1101101;
    localparam logic [6:0] SEG_3    = 7'b1111001;
    localparam logic [6:0] SEG_4    = 7'b0110011;
    localparam logic [6:0] SEG_5    = 7'b1011011;
    localparam logic [6:0] SEG_6    = 7'b1011111;
    localparam logic [6:0] SEG_7    = 7'b1110000;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1111011;
    localparam logic [6:0] SEG_DASH = 7'b0000001;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counter: registered update one cycle after cin, clr wins over cin.
// Combinational carry-out lets a chain of digits roll over in a single edge; no backpressure.
module bcd_digit
    import seg7_pkg::*;
(
    input  logic clkIn,
    input  logic resetIn,
    input  logic clr,
    input  logic cin,
    output bcd_t q,
    output logic cout
);

    bcd_t q_q;
    bcd_t q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (cin) begin
            q_d = (q_q == 4'd9) ? 4'd0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clkIn) begin
        if (!resetIn) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign cout = cin && (q_q == 4'd9);

endmodule

// File: rtl/seg7_scan_counter.sv
// DIGITS-wide BCD event counter with a multiplexed 7-segment scanner; count lands 3 edges
// after an increment rise, display outputs are registered (1 cycle); no backpressure.
module seg7_scan_counter
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int CLK_HZ         = 27_000_000,
    parameter int SLOT_HZ        = 1000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic                  clkIn,
    input  logic                  resetIn,
    input  logic                  increment,
    input  logic                  clear,
    input  logic [DIGITS-1:0]     dpMask,
    output logic [7:0]            segmentEnable,
    output logic [DIGITS-1:0]     digitEnable,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   countOut
);

    localparam int TICK_DIV = CLK_HZ / SLOT_HZ;
    localparam int PRESC_W  = $clog2(TICK_DIV);
    localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [7:0]        SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACTIVE_LOW}};

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic edge_q,  edge_d;
    logic inc_pulse;

    logic               overflow_q, overflow_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         seg_q, seg_d;
    logic [DIGITS-1:0]  dig_q, dig_d;

    bcd_t              digit_q [DIGITS];
    logic [DIGITS:0]   carry;

    always_comb begin
        sync1_d   = increment;
        sync2_d   = sync1_q;
        edge_d    = sync2_q;
        inc_pulse = sync2_q && !edge_q;
    end

    assign carry[0] = inc_pulse;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        bcd_digit u_digit (
            .clkIn   (clkIn),
            .resetIn (resetIn),
            .clr     (clear),
            .cin     (carry[gi]),
            .q       (digit_q[gi]),
            .cout    (carry[gi+1])
        );
        assign countOut[4*gi +: 4] = digit_q[gi];
    end

    always_comb begin
        overflow_d = overflow_q;
        if (clear) begin
            overflow_d = 1'b0;
        end else if (carry[DIGITS]) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == PRESC_W'(TICK_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Display mux: the selected digit is blanked when it and every digit above it are zero.
    always_comb begin
        logic       lead_zero;
        logic [7:0] seg_raw;
        logic [DIGITS-1:0] dig_raw;
        lead_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(idx_q) && digit_q[i] != 4'd0) begin
                lead_zero = 1'b0;
            end
        end
        seg_raw = {bcd_to_seg(digit_q[idx_q]), dpMask[idx_q]};
        if (BLANK_LEADING && idx_q != '0 && lead_zero) begin
            seg_raw[7:1] = 7'b0;
        end
        dig_raw        = '0;
        dig_raw[idx_q] = 1'b1;
        if (presc_q < PRESC_W'(BLANK_CYCLES)) begin
            seg_raw = '0;
            dig_raw = '0;
        end
        seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
        dig_d = DIG_ACTIVE_LOW ? ~dig_raw : dig_raw;
    end

    always_ff @(posedge clkIn) begin
        if (!resetIn) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            edge_q     <= 1'b0;
            overflow_q <= 1'b0;
            presc_q    <= '0;
            idx_q      <= '0;
            seg_q      <= SEG_OFF;
            dig_q      <= DIG_OFF;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            edge_q     <= edge_d;
            overflow_q <= overflow_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            dig_q      <= dig_d;
        end
    end

    assign segmentEnable = seg_q;
    assign digitEnable   = dig_q;
    assign overflow      = overflow_q;

endmodule
